// File: rtl/uart_tx_arbiter.sv
// Two-source arbiter in front of uart_tx: one grant per frame, channel tag in bit 7,
// burst limit keeps the priority channel from starving the other one.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | waiting for uart_tx idle and a valid request; grants here
// S_START     | one-cycle start pulse to uart_tx
// S_WAIT_BUSY | waiting for uart_tx to report busy (ready low)
// S_WAIT_DONE | waiting for uart_tx to return to idle (ready high)
module uart_tx_arbiter #(
    parameter int BURST_MAX = 4,
    parameter int PRIO      = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_p_valid,
    input  logic [6:0] i_p_dat,
    output logic       o_p_ready,
    input  logic       i_d_valid,
    input  logic [6:0] i_d_dat,
    output logic       o_d_ready,
    output logic [7:0] o_tx_dat,
    output logic       o_tx_start,
    input  logic       i_tx_ready,
    output logic       o_busy,
    output logic       o_last_grant
);

    localparam int               CNT_W   = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic             PRIO_CH = (PRIO != 0);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_START     = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [7:0]       tx_dat_q, tx_dat_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic grant_en;
    logic grant_ch;
    logic burst_hit;

    // Grant selection; ready is gated by reset so a reset cycle never consumes a byte.
    always_comb begin
        burst_hit = (last_q == PRIO_CH) && (cnt_q >= CNT_MAX);
        grant_en  = (state_q == S_IDLE) && i_tx_ready && (i_p_valid || i_d_valid) && !i_reset;
        if (i_p_valid && i_d_valid) begin
            grant_ch = burst_hit ? ~PRIO_CH : PRIO_CH;
        end else begin
            grant_ch = i_p_valid;
        end
    end

    always_comb begin
        state_d  = state_q;
        tx_dat_d = tx_dat_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (grant_en) begin
                    state_d  = S_START;
                    tx_dat_d = {grant_ch, (grant_ch ? i_p_dat : i_d_dat)};
                    last_d   = grant_ch;
                    if (grant_ch == last_q) begin
                        cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = CNT_ONE;
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!i_tx_ready) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (i_tx_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            tx_dat_q <= 8'h00;
            last_q   <= ~PRIO_CH;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            tx_dat_q <= tx_dat_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_p_ready    = grant_en & grant_ch;
    assign o_d_ready    = grant_en & ~grant_ch;
    assign o_tx_dat     = tx_dat_q;
    assign o_tx_start   = (state_q == S_START);
    assign o_busy       = (state_q != S_IDLE);
    assign o_last_grant = last_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: frame-level reference model predicts grants,
// a separate monitor checks every start pulse against the predicted byte.
module tb_uart_tx_arbiter;

    localparam int   BM  = 4;
    localparam int   PR  = 1;
    localparam logic PRC = 1'b1;

    logic       clk = 1'b0;
    logic       rst;
    logic       p_valid, d_valid;
    logic [6:0] p_dat, d_dat;
    logic       p_ready, d_ready;
    logic [7:0] tx_dat;
    logic       tx_start;
    logic       uart_rdy, hold_low;
    logic       tx_ready;
    logic       busy, last_grant;

    assign tx_ready = uart_rdy & ~hold_low;

    uart_tx_arbiter #(.BURST_MAX(BM), .PRIO(PR)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_p_valid   (p_valid),
        .i_p_dat     (p_dat),
        .o_p_ready   (p_ready),
        .i_d_valid   (d_valid),
        .i_d_dat     (d_dat),
        .o_d_ready   (d_ready),
        .o_tx_dat    (tx_dat),
        .o_tx_start  (tx_start),
        .i_tx_ready  (tx_ready),
        .o_busy      (busy),
        .o_last_grant(last_grant)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out t=%0t", name, $time);
    endtask

    // Source modes: 0 = feed queue, 1 = random valid, 2 = always valid
    int         p_mode = 0, d_mode = 0;
    logic [6:0] p_feed[$], d_feed[$];

    initial begin : p_src
        logic took;
        p_valid = 1'b0;
        p_dat   = '0;
        forever begin
            @(negedge clk);
            took = p_valid && p_ready;
            @(posedge clk);
            #1;
            if (took || !p_valid) begin
                if (p_mode == 0) begin
                    if (p_feed.size() > 0) begin
                        p_dat = p_feed.pop_front(); p_valid = 1'b1;
                    end else begin
                        p_valid = 1'b0;
                    end
                end else begin
                    p_valid = (p_mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
                    p_dat   = 7'($urandom);
                end
            end
        end
    end

    initial begin : d_src
        logic took;
        d_valid = 1'b0;
        d_dat   = '0;
        forever begin
            @(negedge clk);
            took = d_valid && d_ready;
            @(posedge clk);
            #1;
            if (took || !d_valid) begin
                if (d_mode == 0) begin
                    if (d_feed.size() > 0) begin
                        d_dat = d_feed.pop_front(); d_valid = 1'b1;
                    end else begin
                        d_valid = 1'b0;
                    end
                end else begin
                    d_valid = (d_mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
                    d_dat   = 7'($urandom);
                end
            end
        end
    end

    // uart_tx stand-in: goes busy drop_dly cycles after the start pulse, for busy_len cycles
    int drop_dly = 1, busy_len = 3;
    bit uart_rand = 1'b0;

    initial begin : uart_model
        int dd, bl;
        uart_rdy = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_start && !rst) begin
                dd = uart_rand ? int'($urandom_range(1, 3)) : drop_dly;
                bl = uart_rand ? int'($urandom_range(1, 6)) : busy_len;
                repeat (dd) @(posedge clk);
                #1 uart_rdy = 1'b0;
                repeat (bl) @(posedge clk);
                #1 uart_rdy = 1'b1;
            end
        end
    end

    // Reference model: a frame runs from a grant until uart_tx has gone busy and come back idle.
    logic [7:0] exp_q[$];
    logic [7:0] start_log[$];
    bit         m_busy, m_seen_low;
    logic       m_last, ch, gp, gd;
    int         m_cnt;

    always @(negedge clk) begin
        if (rst) begin
            m_busy     = 1'b0;
            m_seen_low = 1'b0;
            m_last     = ~PRC;
            m_cnt      = 0;
            exp_q.delete();
            check("p_ready_in_reset", p_ready, 0);
            check("d_ready_in_reset", d_ready, 0);
        end else begin
            check("busy", busy, m_busy);
            gp = 1'b0;
            gd = 1'b0;
            if (!m_busy) begin
                if (tx_ready && (p_valid || d_valid)) begin
                    if (p_valid && d_valid) ch = (m_last == PRC && m_cnt >= BM) ? ~PRC : PRC;
                    else                    ch = p_valid;
                    if (ch == m_last) m_cnt = (m_cnt >= BM) ? BM : m_cnt + 1;
                    else              m_cnt = 1;
                    m_last = ch;
                    exp_q.push_back({ch, (ch ? p_dat : d_dat)});
                    gp = ch;
                    gd = ~ch;
                    m_busy     = 1'b1;
                    m_seen_low = 1'b0;
                end
            end else if (!tx_ready) begin
                m_seen_low = 1'b1;
            end else if (m_seen_low) begin
                m_busy = 1'b0;
            end
            check("p_ready", p_ready, gp);
            check("d_ready", d_ready, gd);
        end
    end

    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (!rst && tx_start) begin
            start_log.push_back(tx_dat);
            if (exp_q.size() == 0) begin
                timeout("unexpected_start");
            end else begin
                e = exp_q.pop_front();
                check("tx_dat", tx_dat, e);
                check("last_grant", last_grant, e[7]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int budget);
        int i = 0;
        while (i < budget && start_log.size() < n) begin
            @(negedge clk);
            i++;
        end
        if (start_log.size() < n) timeout("wait_starts");
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (i < budget && !(!p_valid && !d_valid && !busy && tx_ready &&
                               p_feed.size() == 0 && d_feed.size() == 0)) begin
            @(negedge clk);
            i++;
        end
        if (i >= budget) timeout("wait_idle");
    endtask

    int n;
    int exp_seq[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    initial begin
        rst      = 1'b1;
        hold_low = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_tx_dat", tx_dat, 8'h00);
        check("rst_last_grant", last_grant, 0);
        check("rst_tx_start", tx_start, 0);

        n = start_log.size();
        p_feed.push_back(7'h41);
        wait_starts(n + 1, 50);
        if (start_log.size() > n) check("single_p_dat", start_log[n], 8'hC1);
        wait_idle(100);
        check("single_p_last_grant", last_grant, 1);

        n = start_log.size();
        d_feed.push_back(7'h55);
        wait_starts(n + 1, 50);
        if (start_log.size() > n) check("single_d_dat", start_log[n], 8'h55);
        wait_idle(100);

        do_reset();
        n = start_log.size();
        p_mode = 2;
        d_mode = 2;
        wait_starts(n + 10, 500);
        p_mode = 0;
        d_mode = 0;
        for (int i = 0; i < 10; i++) begin
            if (start_log.size() > n + i) check("contend_seq", start_log[n + i][7], exp_seq[i]);
        end
        wait_idle(200);

        drop_dly = 2;
        busy_len = 10;
        p_mode   = 1;
        d_mode   = 1;
        repeat (300) cyc();
        p_mode = 0;
        d_mode = 0;
        wait_idle(200);

        drop_dly = 1;
        busy_len = 3;
        do_reset();
        hold_low = 1'b1;
        p_feed.push_back(7'h12);
        d_feed.push_back(7'h34);
        n = start_log.size();
        repeat (10) cyc();
        check("hold_no_start", start_log.size(), n);
        hold_low = 1'b0;
        wait_starts(n + 2, 100);
        if (start_log.size() > n + 1) begin
            check("hold_first", start_log[n], 8'h92);
            check("hold_second", start_log[n + 1], 8'h34);
        end
        wait_idle(100);

        busy_len = 20;
        do_reset();
        p_mode = 2;
        d_mode = 2;
        begin
            int i = 0;
            while (i < 60 && tx_ready) begin
                @(negedge clk);
                i++;
            end
            if (tx_ready) timeout("wait_tx_busy");
        end
        cyc();
        cyc();
        check("busy_before_reset", busy, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("midreset_busy", busy, 0);
        check("midreset_tx_dat", tx_dat, 8'h00);
        check("midreset_last_grant", last_grant, 0);
        n = start_log.size();
        wait_starts(n + 1, 100);
        if (start_log.size() > n) check("midreset_next_tag", start_log[n][7], 1);
        p_mode = 0;
        d_mode = 0;
        wait_idle(200);

        uart_rand = 1'b1;
        p_mode    = 1;
        d_mode    = 1;
        repeat (2000) cyc();
        p_mode = 0;
        d_mode = 0;
        wait_idle(200);
        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
